// File: rtl/sw_debounce_pkg.sv
// ----------------------------------------------------------------------------
// sw_debounce_pkg
// Shared definitions for the slide-switch debouncer:
//   state_t   - debouncer FSM states (2-bit encoding)
//   cnt_width - width of a counter that must hold values 0..n-1, never below 1
// ----------------------------------------------------------------------------
package sw_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW       = 2'b00,
        ST_WAIT_HIGH = 2'b01,
        ST_HIGH      = 2'b10,
        ST_WAIT_LOW  = 2'b11
    } state_t;

    // $clog2 returns 0 for n <= 1, which would give a zero-width vector.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Sample-strobe prescaler. Counts 0..TICK_DIV-1 and wraps; tick_o is high in
// the cycle where the count sits at TICK_DIV-1, so with TICK_DIV = 1 it is
// permanently high.
// Ports:
//   sysclk  - system clock
//   reset   - synchronous, active-high; clears the count
//   tick_o  - sample strobe, one sysclk cycle every TICK_DIV cycles
// ----------------------------------------------------------------------------
module tick_gen
    import sw_debounce_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic sysclk,
    input  logic reset,
    output logic tick_o
);

    localparam int            PW       = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q;

    // The strobe is decoded straight from the count so the first tick after
    // reset lands on the TICK_DIV-th rising edge.
    assign tick_o = (pre_q == PRE_LAST);

    // Prescaler count: wraps back to zero on the strobe cycle.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            pre_q <= '0;
        end else if (tick_o) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// ----------------------------------------------------------------------------
// sw_debounce
// Debounces the already-synchronized slide-switch level. A new level is only
// accepted after STABLE_COUNT consecutive agreeing samples, taken once per
// tick from tick_gen. Any disagreeing sample during qualification drops back
// to the old stable state without touching the outputs.
// Ports:
//   sysclk      - system clock
//   reset       - synchronous, active-high; clears all state
//   sw_i        - switch level, synchronous to sysclk
//   sw_level_o  - debounced level (registered)
//   rise_o      - one-cycle strobe on 0->1 of sw_level_o (registered)
//   fall_o      - one-cycle strobe on 1->0 of sw_level_o (registered)
//   busy_o      - high while a candidate change is being qualified
// ----------------------------------------------------------------------------
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int TICK_DIV     = 1,
    parameter int STABLE_COUNT = 4
) (
    input  logic sysclk,
    input  logic reset,
    input  logic sw_i,
    output logic sw_level_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int            CW       = cnt_width(STABLE_COUNT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

    logic          tick;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;
    logic          busy_q,  busy_d;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .sysclk (sysclk),
        .reset  (reset),
        .tick_o (tick)
    );

    // Next-state logic. The strobes default low every cycle so they last a
    // single sysclk cycle even when ticks are several cycles apart; everything
    // else holds between ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (tick) begin
            case (state_q)
                ST_LOW: begin
                    if (sw_i) begin
                        state_d = ST_WAIT_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!sw_i) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_HIGH;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_HIGH: begin
                    if (!sw_i) begin
                        state_d = ST_WAIT_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_WAIT_LOW: begin
                    if (sw_i) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_LOW;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == ST_WAIT_HIGH) || (state_d == ST_WAIT_LOW);
    end

    // State and output registers; reset wins over tick and sw_i, so a reset
    // during qualification never lets a strobe through.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign sw_level_o = level_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_sw_debounce.sv
// ----------------------------------------------------------------------------
// tb_sw_debounce
// Drives two debouncer instances (TICK_DIV=1/STABLE_COUNT=4 and
// TICK_DIV=4/STABLE_COUNT=2) from a shared clock and reset. Directed vectors
// carry hand-computed {level, rise, fall, busy} values; a random bounce
// stream is then checked cycle by cycle against a run-length model.
// ----------------------------------------------------------------------------
module tb_sw_debounce;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    logic sw_a   = 1'b0;
    logic sw_b   = 1'b0;

    logic lvl_a, rise_a, fall_a, busy_a;
    logic lvl_b, rise_b, fall_b, busy_b;

    int vecCount  = 0;
    int missCount = 0;

    // Reference model state, index 0 = instance A, 1 = instance B.
    int   td [2] = '{1, 4};
    int   sc [2] = '{4, 2};
    int   mPre [2];
    int   mRun [2];
    logic mLevel [2];
    logic mRise [2];
    logic mFall [2];
    logic mBusy [2];

    sw_debounce #(
        .TICK_DIV     (1),
        .STABLE_COUNT (4)
    ) dut_a (
        .sysclk     (sysclk),
        .reset      (reset),
        .sw_i       (sw_a),
        .sw_level_o (lvl_a),
        .rise_o     (rise_a),
        .fall_o     (fall_a),
        .busy_o     (busy_a)
    );

    sw_debounce #(
        .TICK_DIV     (4),
        .STABLE_COUNT (2)
    ) dut_b (
        .sysclk     (sysclk),
        .reset      (reset),
        .sw_i       (sw_b),
        .sw_level_o (lvl_b),
        .rise_o     (rise_b),
        .fall_o     (fall_b),
        .busy_o     (busy_b)
    );

    always #5 sysclk = ~sysclk;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: counts consecutive samples that differ from the accepted level
    // and flips the level once that run reaches STABLE_COUNT.
    task automatic modelEdge(input int k, input logic sw, input logic rst);
        logic t;
        if (rst) begin
            mPre[k]   = 0;
            mRun[k]   = 0;
            mLevel[k] = 1'b0;
            mRise[k]  = 1'b0;
            mFall[k]  = 1'b0;
            mBusy[k]  = 1'b0;
        end else begin
            t        = (mPre[k] == td[k] - 1);
            mPre[k]  = t ? 0 : mPre[k] + 1;
            mRise[k] = 1'b0;
            mFall[k] = 1'b0;
            if (t) begin
                if (sw != mLevel[k]) begin
                    mRun[k]++;
                    if (mRun[k] == sc[k]) begin
                        mLevel[k] = sw;
                        mRise[k]  = sw;
                        mFall[k]  = !sw;
                        mRun[k]   = 0;
                    end
                end else begin
                    mRun[k] = 0;
                end
                mBusy[k] = (mRun[k] != 0);
            end
        end
    endtask

    // Drives one cycle of inputs, waits for the edge, and steps the model.
    task automatic applyStimulus(input logic rst, input logic swa, input logic swb);
        reset = rst;
        sw_a  = swa;
        sw_b  = swb;
        @(posedge sysclk);
        #1;
        modelEdge(0, swa, rst);
        modelEdge(1, swb, rst);
    endtask

    // Expected {level, rise, fall, busy} tables.
    logic [3:0] expRstA [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b1100, 4'b1000,
                                4'b1000, 4'b1000, 4'b1000, 4'b1000};
    logic [3:0] expRstB [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001,
                                4'b0001, 4'b0001, 4'b1100, 4'b1000};
    logic       swBounce  [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] expBounce [7] = '{4'b1001, 4'b1000, 4'b1001, 4'b1001, 4'b1001,
                                  4'b0010, 4'b0000};
    logic       swGlitch  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] expGlitch [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                                  4'b0000};
    logic       rstAbort  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       swAbort   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0] expAbort  [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000,
                                  4'b0000, 4'b0000, 4'b0000, 4'b0000};

    initial begin
        logic tgtA, tgtB, swa, swb;
        int   lastA, lastB;

        // Reset with the switch held high: everything must read zero.
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("reset_a", {lvl_a, rise_a, fall_a, busy_a}, 4'b0000);
        checkOutput("reset_b", {lvl_b, rise_b, fall_b, busy_b}, 4'b0000);

        // Release reset with the switch still high; A accepts on edge 4,
        // B (first tick on edge 4, two samples) on edge 8.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("post_rst_a%0d", i + 1),
                        {lvl_a, rise_a, fall_a, busy_a}, expRstA[i]);
            checkOutput($sformatf("post_rst_b%0d", i + 1),
                        {lvl_b, rise_b, fall_b, busy_b}, expRstB[i]);
        end

        // Bounce 0,1,0,0,0,0 from the high level: one fall on the 4th zero.
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, swBounce[i], 1'b1);
            checkOutput($sformatf("bounce%0d", i),
                        {lvl_a, rise_a, fall_a, busy_a}, expBounce[i]);
        end

        // Three-cycle high glitch: busy for three cycles, no rise.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, swGlitch[i], 1'b0);
            checkOutput($sformatf("glitch%0d", i),
                        {lvl_a, rise_a, fall_a, busy_a}, expGlitch[i]);
        end

        // Reset on the edge that would accept the new level.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(rstAbort[i], swAbort[i], 1'b0);
            checkOutput($sformatf("abort%0d", i),
                        {lvl_a, rise_a, fall_a, busy_a}, expAbort[i]);
        end

        // Random bounce stream against the model.
        tgtA  = 1'b0;
        tgtB  = 1'b0;
        lastA = -1;
        lastB = -1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 15) == 0) tgtA = ~tgtA;
            if ($urandom_range(0, 23) == 0) tgtB = ~tgtB;
            swa = ($urandom_range(0, 7) == 0) ? ~tgtA : tgtA;
            swb = ($urandom_range(0, 9) == 0) ? ~tgtB : tgtB;
            applyStimulus(1'b0, swa, swb);
            checkOutput("rnd_a", {lvl_a, rise_a, fall_a, busy_a},
                        {mLevel[0], mRise[0], mFall[0], mBusy[0]});
            checkOutput("rnd_b", {lvl_b, rise_b, fall_b, busy_b},
                        {mLevel[1], mRise[1], mFall[1], mBusy[1]});
            checkOutput("rnd_a_both", {31'd0, rise_a & fall_a}, 32'd0);
            checkOutput("rnd_b_both", {31'd0, rise_b & fall_b}, 32'd0);
            if (rise_a || fall_a) begin
                if (lastA >= 0)
                    checkOutput("rnd_a_alt", {31'd0, rise_a}, (lastA == 0) ? 32'd1 : 32'd0);
                lastA = rise_a ? 1 : 0;
            end
            if (rise_b || fall_b) begin
                if (lastB >= 0)
                    checkOutput("rnd_b_alt", {31'd0, rise_b}, (lastB == 0) ? 32'd1 : 32'd0);
                lastB = rise_b ? 1 : 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Debounces the synchronized slide-switch level before it reaches the counter-control and LED logic. Sits directly downstream of the two-stage `sync_meta` on the switch input, in the `sysclk` domain. It outputs a clean level plus single-cycle rise and fall strobes. The control logic uses the fall strobe in place of raw level tests on the switch.

## Interface
Parameters:
- `TICK_DIV`, default 1: `sysclk` cycles per sample strobe. Legal range ≥ 1; 1 means sample every cycle.
- `STABLE_COUNT`, default 4: consecutive agreeing samples required to accept a new level. Legal range ≥ 2.

Ports:
- `sysclk`, input, 1 bit: system clock, the PLL output.
- `reset`, input, 1 bit: synchronous, active-high. Clears all state on the next `sysclk` rising edge.
- `sw_i`, input, 1 bit: switch level, already synchronized to `sysclk`.
- `sw_level_o`, output, 1 bit: debounced level, registered.
- `rise_o`, output, 1 bit: one-cycle pulse when `sw_level_o` goes 0→1, registered.
- `fall_o`, output, 1 bit: one-cycle pulse when `sw_level_o` goes 1→0, registered.
- `busy_o`, output, 1 bit: high while a candidate level change is being qualified (WAIT states).

## Operation
- Reset values:
  - State is `ST_LOW`.
  - `sw_level_o`, `rise_o`, `fall_o` and `busy_o` are 0.
  - Sample counter and prescaler counter are 0.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 and wraps.
  - Strobe `tick` is high in the cycle where the count equals `TICK_DIV`-1.
  - With `TICK_DIV`=1, `tick` is constantly 1.
- The FSM acts only in cycles where `tick`=1. Otherwise it holds all state.
- `ST_LOW`:
  - `sw_i`=1 → `ST_WAIT_HIGH`, counter set to 1.
  - Otherwise stay.
- `ST_WAIT_HIGH`:
  - `sw_i`=0 → `ST_LOW`, counter cleared. This is a glitch; no output change.
  - Otherwise, counter = `STABLE_COUNT`-1 → `ST_HIGH`, `sw_level_o`←1, `rise_o`←1, counter cleared.
  - Otherwise counter increments.
- `ST_HIGH` and `ST_WAIT_LOW` mirror `ST_LOW` and `ST_WAIT_HIGH` with polarity inverted. The accepting transition drives `fall_o`←1.
- `rise_o` and `fall_o` are high for exactly one `sysclk` cycle, regardless of `TICK_DIV`. They are never high together.
- `busy_o` equals (state is a WAIT state), registered with the state.
- Sample counter width: `$clog2(STABLE_COUNT)`, minimum 1. It never exceeds `STABLE_COUNT`-1.
- Prescaler width: `$clog2(TICK_DIV)`, minimum 1.
- `reset` takes priority over `tick` and `sw_i`. Reset mid-qualification aborts qualification: no pulse, level 0.

## Timing
- `TICK_DIV`=1, `sw_i` rising before edge 0 and held:
  - Edge 0 enters `ST_WAIT_HIGH`.
  - `sw_level_o` and `rise_o` go high after edge `STABLE_COUNT`-1.
  - `rise_o` drops after edge `STABLE_COUNT`.
- General acceptance latency: `STABLE_COUNT` ticks from the first differing sample. That is between (`STABLE_COUNT`-1)·`TICK_DIV`+1 and `STABLE_COUNT`·`TICK_DIV` `sysclk` cycles after `sw_i` changes.
- After reset deasserts, the first tick falls on the `TICK_DIV`-th rising edge.
- A glitch shorter than `STABLE_COUNT` consecutive samples produces no output change. The next opposite-level sample restarts qualification from 1.

## Structure
- Package `sw_debounce_pkg` holds:
  - the state enum: `ST_LOW`, `ST_WAIT_HIGH`, `ST_HIGH`, `ST_WAIT_LOW`, 2-bit encoding;
  - the counter-width helper function.
- Sub-module `tick_gen` is the prescaler: parameter `TICK_DIV`, ports `sysclk`, `reset`, `tick_o`. The rest lives in `sw_debounce`.

## Test plan
- Reset with `sw_i`=1 held → outputs all 0 after the reset edge. With `STABLE_COUNT`=4 and `TICK_DIV`=1, `sw_level_o`=1 and a single `rise_o` pulse appear 4 edges after reset deasserts.
- `STABLE_COUNT`=4, `TICK_DIV`=1, `sw_i` pulses high for 3 cycles then low → `sw_level_o` stays 0, no `rise_o`, `busy_o` high for exactly 3 cycles.
- Level high, then `sw_i` bounces 0,1,0,0,0,0 → `fall_o` pulses once, on the 4th consecutive 0 sample; `sw_level_o`=0 thereafter.
- `TICK_DIV`=4, `STABLE_COUNT`=2, `sw_i` steps to 1 → `rise_o` within 5..8 cycles, pulse width exactly 1 cycle.
- `reset` asserted one cycle before acceptance in `ST_WAIT_HIGH` → no `rise_o`, `sw_level_o`=0, `busy_o`=0 after the reset edge.
- Random bounce stream of 10k cycles against a reference model → `rise_o` and `fall_o` counts alternate, each pulse is 1 cycle, and the two are never simultaneous.
